// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and coin constants for the vending front-end controller
//
// Contents:
//   vend_state_t        controller state: ACCEPT, VEND, CHANGE
//   NICKEL_UNITS        credit value of a nickel, in nickel units
//   DIME_UNITS          credit value of a dime, in nickel units
//   DEFAULT_PRICE_UNITS default item price, in nickel units (15 cents)
//   coin_units()        maps a coin-type bit to its credit value

package vend_pkg;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } vend_state_t;

  localparam int NICKEL_UNITS        = 1;
  localparam int DIME_UNITS          = 2;
  localparam int DEFAULT_PRICE_UNITS = 3;

  function automatic int coin_units(input logic dime);
    return dime ? DIME_UNITS : NICKEL_UNITS;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter
//
// Ports:
//   Clock   in   system clock, rising edge
//   Reset   in   synchronous, active-high; pointer returns to requester 0
//   req     in   [1:0] request per requester
//   accept  in   the current grant was taken this cycle; advances the pointer
//   grant   out  [1:0] one-hot (or zero) grant, combinational from req

module rr_arb2 (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // ptr names the requester that wins when both are asking.
  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
  end

  // After an accepted transfer the pointer moves to the requester that did
  // not win, so a contended pair alternates. grant[0] set means requester 0
  // won, so the pointer moves to 1; otherwise requester 1 won and it moves to 0.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - nickel/dime vending front-end: coin arbitration, credit, dispense and change sequencing
//
// Optional feature: define VEND_CTRL_TIMEOUT_EN to auto-refund credit after
// TIMEOUT_CYCLES idle cycles in ACCEPT. Without it credit is held indefinitely.
//
// Ports:
//   Clock       in   system clock, rising edge
//   Reset       in   synchronous, active-high
//   Slot0Valid  in   slot 0 presents a coin
//   Slot0Dime   in   slot 0 coin type (1 = dime, 0 = nickel)
//   Slot0Ready  out  slot 0 coin accepted this cycle (combinational)
//   Slot1Valid  in   slot 1 presents a coin
//   Slot1Dime   in   slot 1 coin type
//   Slot1Ready  out  slot 1 coin accepted this cycle (combinational)
//   Cancel      in   customer refund request, level
//   DispReq     out  dispense request, held until DispAck
//   DispAck     in   dispenser done, single-cycle pulse
//   ChgReq      out  eject-one-nickel request, held through CHANGE
//   ChgAck      in   one nickel ejected, single-cycle pulse
//   Credit      out  [CREDIT_W-1:0] current credit in nickel units
//   Busy        out  high whenever the controller is not in ACCEPT

module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE_UNITS    = DEFAULT_PRICE_UNITS,
  parameter int CREDIT_W       = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Slot0Valid,
  input  logic                Slot0Dime,
  output logic                Slot0Ready,
  input  logic                Slot1Valid,
  input  logic                Slot1Dime,
  output logic                Slot1Ready,
  input  logic                Cancel,
  output logic                DispReq,
  input  logic                DispAck,
  output logic                ChgReq,
  input  logic                ChgAck,
  output logic [CREDIT_W-1:0] Credit,
  output logic                Busy
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_UNITS);
  localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);

  vend_state_t         state;
  logic [1:0]          grant;
  logic                coin_take;
  logic                coin_dime;
  logic [CREDIT_W-1:0] credit_add;
  logic                cancel_go;
  logic                timeout_hit;

  rr_arb2 u_arb (
    .Clock  (Clock),
    .Reset  (Reset),
    .req    ({Slot1Valid, Slot0Valid}),
    .accept (coin_take),
    .grant  (grant)
  );

  // A grant only exists for a valid slot, so Ready alone marks a transfer.
  assign Slot0Ready = (state == ACCEPT) && !Cancel && grant[0];
  assign Slot1Ready = (state == ACCEPT) && !Cancel && grant[1];
  assign coin_take  = Slot0Ready || Slot1Ready;
  assign coin_dime  = Slot0Ready ? Slot0Dime : Slot1Dime;
  assign credit_add = Credit + CREDIT_W'(coin_units(coin_dime));
  assign cancel_go  = Cancel && (Credit != '0);

`ifdef VEND_CTRL_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] idle_cnt;

  assign timeout_hit = (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && (Credit != '0);

  // Counts idle cycles while customer credit sits in ACCEPT; any activity
  // that consumes or returns the credit restarts it.
  always_ff @(posedge Clock) begin
    if (Reset || (state != ACCEPT) || coin_take || cancel_go ||
        (Credit == '0) || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end
  end
`else
  // No timeout: credit is held until spent or cancelled. The comparison is
  // constant-false for any legal TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= ACCEPT;
      Credit  <= '0;
      DispReq <= 1'b0;
      ChgReq  <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      case (state)
        ACCEPT: begin
          if (coin_take) begin
            Credit <= credit_add;
            if (credit_add >= PRICE_C) begin
              state   <= VEND;
              DispReq <= 1'b1;
              Busy    <= 1'b1;
            end
          end else if (cancel_go || timeout_hit) begin
            // Full refund is paid out one nickel at a time through CHANGE.
            state  <= CHANGE;
            ChgReq <= 1'b1;
            Busy   <= 1'b1;
          end
        end

        VEND: begin
          if (DispAck) begin
            DispReq <= 1'b0;
            if (Credit > PRICE_C) begin
              Credit <= Credit - PRICE_C;
              state  <= CHANGE;
              ChgReq <= 1'b1;
            end else begin
              Credit <= '0;
              state  <= ACCEPT;
              Busy   <= 1'b0;
            end
          end
        end

        CHANGE: begin
          if (ChgAck) begin
            Credit <= Credit - ONE_C;
            if (Credit == ONE_C) begin
              state  <= ACCEPT;
              ChgReq <= 1'b0;
              Busy   <= 1'b0;
            end
          end
        end

        default: begin
          state   <= ACCEPT;
          Credit  <= '0;
          DispReq <= 1'b0;
          ChgReq  <= 1'b0;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - self-checking bench for vend_controller: directed vector table plus randomized run against a reference model

module tb_vend_controller;

  localparam int PRICE      = 3;
  localparam int CW         = 3;
  localparam int TB_TIMEOUT = 8;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Slot0Valid = 1'b0, Slot0Dime = 1'b0, Slot1Valid = 1'b0, Slot1Dime = 1'b0;
  logic          Cancel = 1'b0, DispAck = 1'b0, ChgAck = 1'b0;
  logic          Slot0Ready, Slot1Ready, DispReq, ChgReq, Busy;
  logic [CW-1:0] Credit;

  int checks   = 0;
  int failures = 0;

  vend_controller #(
    .PRICE_UNITS    (PRICE),
    .CREDIT_W       (CW),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Slot0Valid (Slot0Valid),
    .Slot0Dime  (Slot0Dime),
    .Slot0Ready (Slot0Ready),
    .Slot1Valid (Slot1Valid),
    .Slot1Dime  (Slot1Dime),
    .Slot1Ready (Slot1Ready),
    .Cancel     (Cancel),
    .DispReq    (DispReq),
    .DispAck    (DispAck),
    .ChgReq     (ChgReq),
    .ChgAck     (ChgAck),
    .Credit     (Credit),
    .Busy       (Busy)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] in;   // {rst, v0, d0, v1, d1, cancel, dack, cack}
    logic [1:0] rdy;  // {r0, r1} expected during the cycle
    int         cr;   // expected Credit after the edge
    logic [2:0] outs; // {DispReq, ChgReq, Busy} expected after the edge
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [7:0] in, logic [1:0] rdy, int cr, logic [2:0] outs);
    vec_t v;
    v.in = in; v.rdy = rdy; v.cr = cr; v.outs = outs;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] in);
    {Reset, Slot0Valid, Slot0Dime, Slot1Valid, Slot1Dime, Cancel, DispAck, ChgAck} = in;
  endtask

  task automatic check_regs(input string tag, input int cr, input logic [2:0] outs);
    check({tag, "_credit"}, int'(Credit), cr);
    check({tag, "_dispreq"}, int'(DispReq), int'(outs[2]));
    check({tag, "_chgreq"}, int'(ChgReq), int'(outs[1]));
    check({tag, "_busy"}, int'(Busy), int'(outs[0]));
  endtask

  // One cycle: drive at negedge, check Ready mid-cycle, check registers after the edge.
  task automatic step(input string tag, input logic [7:0] in, input logic [1:0] rdy,
                      input int cr, input logic [2:0] outs);
    @(negedge Clock);
    drive(in);
    #1;
    check({tag, "_ready0"}, int'(Slot0Ready), int'(rdy[1]));
    check({tag, "_ready1"}, int'(Slot1Ready), int'(rdy[0]));
    @(posedge Clock);
    #1;
    check_regs(tag, cr, outs);
  endtask

  // Reference model: plain description of the vending rules.
  int m_mode;  // 0 taking coins, 1 dispensing, 2 paying change
  int m_cr, m_ptr, m_idle;

  task automatic model_reset();
    m_mode = 0; m_cr = 0; m_ptr = 0; m_idle = 0;
  endtask

  function automatic int model_grant(logic v0, logic v1, logic can);
    if (m_mode != 0 || can) return -1;
    if (v0 && v1) return m_ptr;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_step(input logic rst, input logic v0, input logic d0, input logic v1,
                            input logic d1, input logic can, input logic dack, input logic cack);
    int g;
    g = model_grant(v0, v1, can);
    if (rst) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (g >= 0) begin
        m_cr  += ((g == 0) ? d0 : d1) ? 2 : 1;
        m_ptr  = 1 - g;
        m_idle = 0;
        if (m_cr >= PRICE) m_mode = 1;
      end else if (can && m_cr > 0) begin
        m_mode = 2;
        m_idle = 0;
      end else if (m_cr == 0) begin
        m_idle = 0;
      end else begin
`ifdef VEND_CTRL_TIMEOUT_EN
        if (m_idle == TB_TIMEOUT - 1) begin
          m_mode = 2;
          m_idle = 0;
        end else begin
          m_idle++;
        end
`else
        m_idle++;
`endif
      end
    end else if (m_mode == 1) begin
      if (dack) begin
        m_cr  -= PRICE;
        m_mode = (m_cr > 0) ? 2 : 0;
      end
    end else begin
      if (cack) begin
        m_cr--;
        if (m_cr == 0) m_mode = 0;
      end
    end
  endtask

  initial begin
    logic [7:0] rin;
    int g;

    // Reset state
    drive(8'b1000_0000);
    repeat (2) @(posedge Clock);
    #1;
    check_regs("reset", 0, 3'b000);

    // Directed vectors: {rst,v0,d0,v1,d1,cancel,dack,cack}, {r0,r1}, credit, {dreq,creq,busy}
    tbl.push_back(mk(8'b0100_0000, 2'b10, 1, 3'b000)); // three nickels on slot 0
    tbl.push_back(mk(8'b0100_0000, 2'b10, 2, 3'b000));
    tbl.push_back(mk(8'b0100_0000, 2'b10, 3, 3'b101));
    tbl.push_back(mk(8'b0000_0000, 2'b00, 3, 3'b101)); // DispReq holds
    tbl.push_back(mk(8'b0000_0010, 2'b00, 0, 3'b000)); // exact price: no change
    tbl.push_back(mk(8'b0110_0000, 2'b10, 2, 3'b000)); // dime slot 0
    tbl.push_back(mk(8'b0001_1000, 2'b01, 4, 3'b101)); // dime slot 1 -> max credit
    tbl.push_back(mk(8'b0000_0010, 2'b00, 1, 3'b011)); // one nickel change
    tbl.push_back(mk(8'b0000_0001, 2'b00, 0, 3'b000));
    tbl.push_back(mk(8'b0101_0000, 2'b10, 1, 3'b000)); // contention alternates 0,1,0
    tbl.push_back(mk(8'b0101_0000, 2'b01, 2, 3'b000));
    tbl.push_back(mk(8'b0101_0000, 2'b10, 3, 3'b101));
    tbl.push_back(mk(8'b0101_0001, 2'b00, 3, 3'b101)); // coins and ChgAck ignored in VEND
    tbl.push_back(mk(8'b0000_0010, 2'b00, 0, 3'b000));
    tbl.push_back(mk(8'b0001_1000, 2'b01, 2, 3'b000));
    tbl.push_back(mk(8'b0000_0010, 2'b00, 2, 3'b000)); // DispAck ignored in ACCEPT
    tbl.push_back(mk(8'b0100_0100, 2'b00, 2, 3'b011)); // Cancel beats coin
    tbl.push_back(mk(8'b0100_0110, 2'b00, 2, 3'b011)); // Cancel/DispAck ignored in CHANGE
    tbl.push_back(mk(8'b0000_0001, 2'b00, 1, 3'b011));
    tbl.push_back(mk(8'b0000_0001, 2'b00, 0, 3'b000));
    tbl.push_back(mk(8'b0000_0100, 2'b00, 0, 3'b000)); // Cancel with no credit ignored
    tbl.push_back(mk(8'b0001_1000, 2'b01, 2, 3'b000));
    tbl.push_back(mk(8'b0110_0000, 2'b10, 4, 3'b101)); // pointer now at slot 1
    tbl.push_back(mk(8'b1100_0000, 2'b00, 0, 3'b000)); // reset mid-dispense
    tbl.push_back(mk(8'b0101_0000, 2'b10, 1, 3'b000)); // pointer back at slot 0
    tbl.push_back(mk(8'b0101_0000, 2'b01, 2, 3'b000));
    tbl.push_back(mk(8'b0001_1000, 2'b01, 4, 3'b101));
    tbl.push_back(mk(8'b0000_0010, 2'b00, 1, 3'b011));
    tbl.push_back(mk(8'b0000_0001, 2'b00, 0, 3'b000));

    foreach (tbl[i]) begin
      step($sformatf("vec%0d", i), tbl[i].in, tbl[i].rdy, tbl[i].cr, tbl[i].outs);
    end

    // Idle credit: timeout refund when enabled, held otherwise.
    step("to_coin", 8'b0100_0000, 2'b10, 1, 3'b000);
    for (int k = 0; k < TB_TIMEOUT - 1; k++) begin
      step($sformatf("to_idle%0d", k), 8'b0000_0000, 2'b00, 1, 3'b000);
    end
`ifdef VEND_CTRL_TIMEOUT_EN
    step("to_fire", 8'b0000_0000, 2'b00, 1, 3'b011);
    step("to_ack", 8'b0000_0001, 2'b00, 0, 3'b000);
`else
    step("to_hold", 8'b0000_0000, 2'b00, 1, 3'b000);
    repeat (40) @(posedge Clock);
    #1;
    check_regs("to_hold_long", 1, 3'b000);
    step("to_cancel", 8'b0000_0100, 2'b00, 1, 3'b011);
    step("to_ack", 8'b0000_0001, 2'b00, 0, 3'b000);
`endif

    // Randomized run against the reference model.
    @(negedge Clock);
    drive(8'b1000_0000);
    @(posedge Clock);
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clock);
      check_regs($sformatf("rnd%0d", c), m_cr,
                 {m_mode == 1, m_mode == 2, m_mode != 0});
      rin[7] = ($urandom_range(0, 199) == 0);
      rin[6] = $urandom_range(0, 1);
      rin[5] = $urandom_range(0, 1);
      rin[4] = $urandom_range(0, 1);
      rin[3] = $urandom_range(0, 1);
      rin[2] = ($urandom_range(0, 9) == 0);
      rin[1] = ($urandom_range(0, 2) == 0);
      rin[0] = ($urandom_range(0, 4) < 2);
      // Long idle stretches give credit a chance to sit in ACCEPT.
      if ($urandom_range(0, 3) == 0) rin[6:3] = 4'b0000;
      drive(rin);
      #1;
      g = model_grant(rin[6], rin[4], rin[2]);
      check($sformatf("rnd%0d_ready0", c), int'(Slot0Ready), int'(g == 0));
      check($sformatf("rnd%0d_ready1", c), int'(Slot1Ready), int'(g == 1));
      model_step(rin[7], rin[6], rin[5], rin[4], rin[3], rin[2], rin[1], rin[0]);
      @(posedge Clock);
    end
    #1;
    check_regs("rnd_final", m_cr, {m_mode == 1, m_mode == 2, m_mode != 0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
